// File: rtl/fios_operand_server.sv
// Operand/result server for the FIOS multiplier: host-loaded A/B/P/p'_0 storage, request-driven
// operand windows, result collection. Optional FIOS_OPSRV_CHECK_EN adds a sticky protocol flag.
module fios_operand_server #(
   parameter int unsigned s     = 8,
   parameter int unsigned PE_NB = 8
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic                          ld_en_i,
   input  logic [1:0]                    ld_sel_i,
   input  logic [$clog2(s)-1:0]          ld_addr_i,
   input  logic [16:0]                   ld_data_i,
   input  logic                          go_i,
   input  logic [$clog2(s)-1:0]          rd_addr_i,
   output logic [16:0]                   rd_data_o,
   output logic                          busy_o,
   output logic                          res_valid_o,
   output logic                          err_o,
   output logic                          start_o,
   output logic [16:0]                   p_prime_0_o,
   output logic [PE_NB*17-1:0]           a_o,
   output logic [16:0]                   b_o,
   output logic [16:0]                   p_o,
   input  logic                          a_shift_i,
   input  logic                          b_fetch_i,
   input  logic                          p_fetch_i,
   input  logic                          RES_push_i,
   input  logic                          done_i,
   input  logic [16:0]                   RES_i
);
   localparam int unsigned AW = $clog2(s);
   localparam int unsigned PW = $clog2(s + PE_NB + 1);
   localparam int unsigned RW = $clog2(s + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
   state_e state_q, state_d;

   logic [16:0] a_mem [s];
   logic [16:0] b_mem [s];
   logic [16:0] p_mem [s];
   logic [16:0] res_mem [s];

   logic [PW-1:0]       a_idx_q, a_idx_d;
   logic [AW-1:0]       b_idx_q, b_idx_d, p_idx_q, p_idx_d;
   logic [RW-1:0]       res_ptr_q, res_ptr_d;
   logic [PE_NB*17-1:0] a_q, a_d;
   logic [16:0]         b_q, b_d, p_q, p_d, pp0_q, rd_q;
   logic                start_q, start_d;
   logic                run, go_acc, ld_ok, addr_ok, push_acc, shift_acc, a_done;

   assign run       = (state_q == StRun);
   assign go_acc    = go_i & ~run;
   assign ld_ok     = ld_en_i & ~run;
   assign addr_ok   = 32'(ld_addr_i) < s;
   assign a_done    = 32'(a_idx_q) >= s;
   assign shift_acc = run & a_shift_i & ~a_done;
   assign push_acc  = run & RES_push_i & (res_ptr_q < RW'(s));

   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      a_idx_d   = a_idx_q;
      b_idx_d   = b_idx_q;
      p_idx_d   = p_idx_q;
      res_ptr_d = res_ptr_q;
      a_d       = a_q;
      b_d       = b_q;
      p_d       = p_q;
      unique case (state_q)
         StIdle, StDone: if (go_i) state_d = StRun;
         StRun:          if (done_i) state_d = StDone;
         default:        state_d = StIdle;
      endcase
      if (go_acc) begin
         start_d   = 1'b1;
         a_idx_d   = '0;
         b_idx_d   = '0;
         p_idx_d   = '0;
         res_ptr_d = '0;
         b_d       = b_mem[0];
         p_d       = p_mem[0];
      end
      if (shift_acc) a_idx_d = a_idx_q + PW'(PE_NB);
      if (run && b_fetch_i) begin
         b_idx_d = (b_idx_q == AW'(s - 1)) ? '0 : b_idx_q + AW'(1);
         b_d     = b_mem[b_idx_d];
      end
      if (run && p_fetch_i) begin
         p_idx_d = (p_idx_q == AW'(s - 1)) ? '0 : p_idx_q + AW'(1);
         p_d     = p_mem[p_idx_d];
      end
      if (push_acc) res_ptr_d = res_ptr_q + RW'(1);
      // Window words past the operand end read as zero; the window never wraps.
      if (go_acc || shift_acc) begin
         for (int unsigned i = 0; i < PE_NB; i++) begin
            a_d[i*17 +: 17] = '0;
            if (32'(a_idx_d) + i < s) a_d[i*17 +: 17] = a_mem[AW'(32'(a_idx_d) + i)];
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         start_q   <= 1'b0;
         a_idx_q   <= '0;
         b_idx_q   <= '0;
         p_idx_q   <= '0;
         res_ptr_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         p_q       <= '0;
         pp0_q     <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         a_idx_q   <= a_idx_d;
         b_idx_q   <= b_idx_d;
         p_idx_q   <= p_idx_d;
         res_ptr_q <= res_ptr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         p_q       <= p_d;
         if (ld_ok && ld_sel_i == 2'd3) pp0_q <= ld_data_i;
         rd_q <= (32'(rd_addr_i) < s) ? res_mem[rd_addr_i] : '0;
      end
   end

   // Storage has no reset so contents survive a mid-run reset.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         if (ld_ok && addr_ok) begin
            case (ld_sel_i)
               2'd0:    a_mem[ld_addr_i] <= ld_data_i;
               2'd1:    b_mem[ld_addr_i] <= ld_data_i;
               2'd2:    p_mem[ld_addr_i] <= ld_data_i;
               default: ;
            endcase
         end
         if (push_acc) res_mem[res_ptr_q[AW-1:0]] <= RES_i;
      end
   end

`ifdef FIOS_OPSRV_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (go_acc) begin
         err_d = 1'b0;
      end else if (run) begin
         if (RES_push_i && !push_acc) err_d = 1'b1;
         if (done_i && res_ptr_d != RW'(s)) err_d = 1'b1;
         if (a_shift_i && a_done) err_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) err_q <= 1'b0;
      else         err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign rd_data_o   = rd_q;
   assign busy_o      = run;
   assign res_valid_o = (state_q == StDone);
   assign start_o     = start_q;
   assign p_prime_0_o = pp0_q;
   assign a_o         = a_q;
   assign b_o         = b_q;
   assign p_o         = p_q;

endmodule

// File: tb/tb_fios_operand_server.sv
// Bench for fios_operand_server (s=8, PE_NB=3): directed scenarios then random traffic, all
// outputs compared every cycle against a behavioural model.
module tb_fios_operand_server;
   localparam int S  = 8;
   localparam int PE = 3;
`ifdef FIOS_OPSRV_CHECK_EN
   localparam bit ChkEn = 1'b1;
`else
   localparam bit ChkEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ld_en, go, a_shift, b_fetch, p_fetch, push, done;
   logic [1:0] ld_sel;
   logic [2:0] ld_addr, rd_addr;
   logic [16:0] ld_data, res_in;
   logic [16:0] rd_data, pp0, b_out, p_out;
   logic [PE*17-1:0] a_out;
   logic busy, res_valid, err, start;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [16:0] ma [S];
   logic [16:0] mb [S];
   logic [16:0] mp [S];
   logic [16:0] mres [S];
   bit          mres_ok [S];
   int          st;  // 0 idle, 1 run, 2 done
   int          a_base, b_idx, p_idx, rptr;
   bit          m_err, e_start, rd_chk;
   logic [16:0] e_b, e_p, e_pp0, e_rd;
   logic [PE*17-1:0] e_a;

   fios_operand_server #(.s(S), .PE_NB(PE)) dut (
      .clock_i(clk), .reset_i(rst), .ld_en_i(ld_en), .ld_sel_i(ld_sel), .ld_addr_i(ld_addr),
      .ld_data_i(ld_data), .go_i(go), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .busy_o(busy),
      .res_valid_o(res_valid), .err_o(err), .start_o(start), .p_prime_0_o(pp0), .a_o(a_out),
      .b_o(b_out), .p_o(p_out), .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch),
      .RES_push_i(push), .done_i(done), .RES_i(res_in)
   );

   always #5 clk = ~clk;

   function automatic logic [PE*17-1:0] win(input int base);
      logic [PE*17-1:0] w;
      w = '0;
      for (int i = 0; i < PE; i++) if (base + i < S) w[i*17 +: 17] = ma[base + i];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         st = 0; e_start = 0; e_a = '0; e_b = '0; e_p = '0; e_pp0 = '0; e_rd = '0;
         rd_chk = 1; m_err = 0; a_base = 0; b_idx = 0; p_idx = 0; rptr = 0;
      end else begin
         rd_chk  = mres_ok[rd_addr];
         e_rd    = mres[rd_addr];
         e_start = 0;
         if (st != 1) begin
            if (go) begin
               st = 1; e_start = 1; a_base = 0; b_idx = 0; p_idx = 0; rptr = 0; m_err = 0;
               e_a = win(0); e_b = mb[0]; e_p = mp[0];
            end
            if (ld_en) begin
               case (ld_sel)
                  2'd0: ma[ld_addr] = ld_data;
                  2'd1: mb[ld_addr] = ld_data;
                  2'd2: mp[ld_addr] = ld_data;
                  default: e_pp0 = ld_data;
               endcase
            end
         end else begin
            if (a_shift) begin
               if (a_base < S) begin
                  a_base += PE;
                  e_a = win(a_base);
               end else m_err = 1;
            end
            if (b_fetch) begin b_idx = (b_idx + 1) % S; e_b = mb[b_idx]; end
            if (p_fetch) begin p_idx = (p_idx + 1) % S; e_p = mp[p_idx]; end
            if (push) begin
               if (rptr < S) begin
                  mres[rptr] = res_in; mres_ok[rptr] = 1; rptr++;
               end else m_err = 1;
            end
            if (done) begin
               if (rptr != S) m_err = 1;
               st = 2;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      chk("busy", 64'(busy), 64'(st == 1));
      chk("res_valid", 64'(res_valid), 64'(st == 2));
      chk("start", 64'(start), 64'(e_start));
      chk("a_o", 64'(a_out), 64'(e_a));
      chk("b_o", 64'(b_out), 64'(e_b));
      chk("p_o", 64'(p_out), 64'(e_p));
      chk("p_prime_0", 64'(pp0), 64'(e_pp0));
      chk("err", 64'(err), 64'(ChkEn & m_err));
      if (rd_chk) chk("rd_data", 64'(rd_data), 64'(e_rd));
   endtask

   task automatic idle_in();
      rst = 0; ld_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; go = 0; rd_addr = 0;
      a_shift = 0; b_fetch = 0; p_fetch = 0; push = 0; done = 0; res_in = 0;
   endtask

   initial begin
      idle_in();
      rst = 1;
      tick();
      tick();
      rst = 0;
      // Load operands
      for (int i = 0; i < S; i++) begin
         ld_en = 1; ld_sel = 0; ld_addr = 3'(i); ld_data = 17'(i + 1); tick();
         ld_sel = 1; ld_data = 17'(i + 9); tick();
         ld_sel = 2; ld_data = 17'(i + 17); tick();
      end
      ld_sel = 3; ld_addr = 3'd6; ld_data = 17'h1234; tick();
      idle_in(); done = 1; tick();                 // done in IDLE ignored
      idle_in(); go = 1; tick();
      idle_in();
      chk("a_o_first", 64'(a_out), 64'({17'd3, 17'd2, 17'd1}));
      chk("b_o_first", 64'(b_out), 64'd9);
      tick();
      go = 1; ld_en = 1; ld_sel = 1; ld_addr = 3'd2; ld_data = 17'h1FFFF; tick();
      idle_in();
      for (int i = 0; i < S; i++) begin
         b_fetch = 1; p_fetch = (i < 3); tick();
      end
      idle_in();
      chk("b_o_wrap", 64'(b_out), 64'd9);
      chk("p_o_step", 64'(p_out), 64'd20);
      a_shift = 1; tick();
      chk("a_o_shift1", 64'(a_out), 64'({17'd6, 17'd5, 17'd4}));
      tick();
      chk("a_o_shift2", 64'(a_out), 64'({17'd0, 17'd8, 17'd7}));
      tick();
      chk("a_o_shift3", 64'(a_out), 64'd0);
      tick();                                      // shift past end
      idle_in();
      for (int i = 0; i < 3; i++) begin
         push = 1; res_in = 17'($urandom_range(0, 17'h1FFFF)); tick();
      end
      idle_in(); rst = 1; tick();
      idle_in(); tick();
      chk("busy_after_rst", 64'(busy), 64'd0);
      go = 1; tick();
      idle_in(); b_fetch = 1; tick(); tick();
      idle_in();
      chk("b2_kept", 64'(b_out), 64'd11);
      for (int i = 0; i < S; i++) begin
         push = 1; res_in = 17'h10000 + 17'(i); tick();
      end
      idle_in(); done = 1; tick();
      idle_in(); rd_addr = 3'd5; tick();
      chk("res_valid_done", 64'(res_valid), 64'd1);
      chk("rd5", 64'(rd_data), 64'h10005);
      idle_in(); go = 1; tick();
      idle_in();
      for (int i = 0; i < S; i++) begin
         push = 1; res_in = 17'($urandom_range(0, 17'h1FFFF)); tick();
      end
      push = 1; done = 1; res_in = 17'h0ABCD; tick();
      idle_in(); tick();
      chk("err_drop_done", 64'(err), 64'(ChkEn));
      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 149) == 0);
         go      = ($urandom_range(0, 19) == 0);
         done    = ($urandom_range(0, 24) == 0);
         push    = ($urandom_range(0, 2) == 0);
         res_in  = 17'($urandom_range(0, 17'h1FFFF));
         a_shift = ($urandom_range(0, 5) == 0);
         b_fetch = 1'($urandom_range(0, 1));
         p_fetch = 1'($urandom_range(0, 1));
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_sel  = 2'($urandom_range(0, 3));
         ld_addr = 3'($urandom_range(0, 7));
         ld_data = 17'($urandom_range(0, 17'h1FFFF));
         rd_addr = 3'($urandom_range(0, 7));
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
